rename_stage_nw: RTL

// - WIDTH-wide register-rename stage owning speculative RAT, committed RAT and both free lists.
// - Sits between decode and dispatch; renames up to WIDTH instrs/cycle with intra-group dependency bypass.
// - Reclaims registers on ROB commit; restores committed state in one cycle on flush.

---
 rtl/rename_pkg.sv | 32 +++
 rtl/rename_stage_nw_free_list_alloc.sv | 42 ++++
 rtl/rename_stage_nw.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/rename_pkg.sv
// Shared types for the rename stage.
// Architectural-register constants, tag types and the request/response/commit payloads.
package rename_pkg;

   localparam int unsigned NUM_AREGS = 32;
   localparam int unsigned AW        = 5;
   localparam int unsigned DEF_PW    = 6;

   typedef logic [AW-1:0]     areg_t;
   typedef logic [DEF_PW-1:0] preg_t;

   typedef struct packed {
      areg_t rs1;
      areg_t rs2;
      areg_t rd;
   } rename_req_t;

   typedef struct packed {
      preg_t p_rs1;
      preg_t p_rs2;
      preg_t p_rd;
      preg_t p_old_rd;
   } rename_rsp_t;

   typedef struct packed {
      logic  valid;
      areg_t rd;
      preg_t p_rd;
      preg_t p_old_rd;
   } commit_t;

endpackage

// File: rtl/rename_stage_nw_free_list_alloc.sv
// Free-list allocator: picks the lowest WIDTH set bits of free_vec (bit 0 excluded).
// Ports: free_vec (free bitmap), req_cnt (tags wanted), tag (picked tags in ascending order),
//        grant (bitmap of the first req_cnt picks), ok (enough tags for req_cnt).
module free_list_alloc #(
   parameter int unsigned WIDTH     = 2,
   parameter int unsigned NUM_PREGS = 64,
   parameter int unsigned PW        = 6,
   parameter int unsigned CW        = 2
) (
   input  logic [NUM_PREGS-1:0]      free_vec,
   input  logic [CW-1:0]             req_cnt,
   output logic [WIDTH-1:0][PW-1:0]  tag,
   output logic [NUM_PREGS-1:0]      grant,
   output logic                      ok
);

   // Priority-encoder chain: each stage removes its pick from the vector seen by the next.
   always_comb begin
      logic [NUM_PREGS-1:0] remain;
      logic [WIDTH-1:0]     found;
      remain    = free_vec;
      remain[0] = 1'b0;
      tag       = '0;
      found     = '0;
      grant     = '0;
      ok        = 1'b1;
      for (int w = 0; w < int'(WIDTH); w++) begin
         for (int i = int'(NUM_PREGS) - 1; i > 0; i--) begin
            if (remain[i]) begin
               tag[w]   = PW'(i);
               found[w] = 1'b1;
            end
         end
         if (found[w]) remain[tag[w]] = 1'b0;
         if (w < int'(req_cnt)) begin
            if (found[w]) grant[tag[w]] = 1'b1;
            else          ok = 1'b0;
         end
      end
   end

endmodule

// File: rtl/rename_stage_nw.sv
// WIDTH-wide register rename stage: speculative/committed RATs and free lists,
// intra-group bypass, commit reclaim and single-cycle flush recovery.
// Ports: clk/rst_n; in_* decode group (valid/ready handshake); out_* renamed group
//        (valid/ready); cm_* per-slot in-order commits; flush squashes speculation.
module rename_stage_nw
   import rename_pkg::*;
#(
   parameter  int unsigned WIDTH     = 2,
   parameter  int unsigned NUM_PREGS = 64,
   localparam int unsigned PW        = $clog2(NUM_PREGS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0][4:0]     in_rs1,
   input  logic [WIDTH-1:0][4:0]     in_rs2,
   input  logic [WIDTH-1:0][4:0]     in_rd,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0][PW-1:0]  out_p_rs1,
   output logic [WIDTH-1:0][PW-1:0]  out_p_rs2,
   output logic [WIDTH-1:0][PW-1:0]  out_p_rd,
   output logic [WIDTH-1:0][PW-1:0]  out_p_old_rd,
   input  logic [WIDTH-1:0]          cm_valid,
   input  logic [WIDTH-1:0][4:0]     cm_rd,
   input  logic [WIDTH-1:0][PW-1:0]  cm_p_rd,
   input  logic [WIDTH-1:0][PW-1:0]  cm_p_old_rd,
   input  logic                      flush
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [NUM_PREGS-1:0] FREE_RST =
      {{(NUM_PREGS - NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};

   logic [PW-1:0]        spec_rat [NUM_AREGS];
   logic [PW-1:0]        arch_rat [NUM_AREGS];
   logic [PW-1:0]        spec_rat_nxt [NUM_AREGS];
   logic [PW-1:0]        arch_rat_nxt [NUM_AREGS];
   logic [NUM_PREGS-1:0] spec_free, arch_free, spec_free_nxt, arch_free_nxt, free_mask;

   rename_req_t              req [WIDTH];
   logic [WIDTH-1:0]         need;
   logic [CW-1:0]            req_cnt;
   logic [WIDTH-1:0][PW-1:0] pick_tag, new_rd, p_rs1, p_rs2, p_old_rd;
   logic [NUM_PREGS-1:0]     grant;
   logic                     alloc_ok, fire;

   free_list_alloc #(
      .WIDTH(WIDTH), .NUM_PREGS(NUM_PREGS), .PW(PW), .CW(CW)
   ) u_alloc (
      .free_vec(spec_free),
      .req_cnt (req_cnt),
      .tag     (pick_tag),
      .grant   (grant),
      .ok      (alloc_ok)
   );

   // Slots with a destination take consecutive picks in slot order.
   always_comb begin
      int cnt;
      cnt    = 0;
      need   = '0;
      new_rd = '0;
      for (int j = 0; j < int'(WIDTH); j++) begin
         req[j] = '{rs1: in_rs1[j], rs2: in_rs2[j], rd: in_rd[j]};
         need[j] = (in_rd[j] != '0);
         if (need[j]) begin
            for (int w = 0; w < int'(WIDTH); w++)
               if (w == cnt) new_rd[j] = pick_tag[w];
            cnt++;
         end
      end
      req_cnt = CW'(cnt);
   end

   // Source/old-dest lookup: the youngest older slot writing the same reg overrides the RAT.
   always_comb begin
      for (int j = 0; j < int'(WIDTH); j++) begin
         p_rs1[j]    = spec_rat[req[j].rs1];
         p_rs2[j]    = spec_rat[req[j].rs2];
         p_old_rd[j] = spec_rat[req[j].rd];
         for (int k = 0; k < j; k++) begin
            if (need[k] && req[k].rd == req[j].rs1) p_rs1[j]    = new_rd[k];
            if (need[k] && req[k].rd == req[j].rs2) p_rs2[j]    = new_rd[k];
            if (need[k] && req[k].rd == req[j].rd)  p_old_rd[j] = new_rd[k];
         end
         if (req[j].rs1 == '0) p_rs1[j]    = '0;
         if (req[j].rs2 == '0) p_rs2[j]    = '0;
         if (req[j].rd  == '0) p_old_rd[j] = '0;
      end
   end

   assign in_ready = !flush && (!out_valid || out_ready) && alloc_ok;
   assign fire     = in_valid && in_ready;

   // Commit path, applied slot by slot so a later slot may free an earlier slot's tag.
   always_comb begin
      arch_rat_nxt  = arch_rat;
      arch_free_nxt = arch_free;
      free_mask     = '0;
      for (int s = 0; s < int'(WIDTH); s++) begin
         if (cm_valid[s] && cm_rd[s] != '0) begin
            arch_rat_nxt[cm_rd[s]]       = cm_p_rd[s];
            arch_free_nxt[cm_p_rd[s]]    = 1'b0;
            arch_free_nxt[cm_p_old_rd[s]] = 1'b1;
            free_mask[cm_p_old_rd[s]]    = 1'b1;
         end
      end
      arch_free_nxt[0] = 1'b0;
      free_mask[0]     = 1'b0;
   end

   // Speculative state: rename updates plus commit frees, or a copy of committed state on flush.
   always_comb begin
      spec_rat_nxt  = spec_rat;
      spec_free_nxt = (spec_free & ~(fire ? grant : '0)) | free_mask;
      if (fire)
         for (int j = 0; j < int'(WIDTH); j++)
            if (need[j]) spec_rat_nxt[req[j].rd] = new_rd[j];
      if (flush) begin
         spec_rat_nxt  = arch_rat_nxt;
         spec_free_nxt = arch_free_nxt;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_AREGS); i++) begin
            spec_rat[i] <= PW'(i);
            arch_rat[i] <= PW'(i);
         end
         spec_free    <= FREE_RST;
         arch_free    <= FREE_RST;
         out_valid    <= 1'b0;
         out_p_rs1    <= '0;
         out_p_rs2    <= '0;
         out_p_rd     <= '0;
         out_p_old_rd <= '0;
      end else begin
         spec_rat  <= spec_rat_nxt;
         arch_rat  <= arch_rat_nxt;
         spec_free <= spec_free_nxt;
         arch_free <= arch_free_nxt;
         if (flush) begin
            out_valid <= 1'b0;
         end else if (fire) begin
            out_valid    <= 1'b1;
            out_p_rs1    <= p_rs1;
            out_p_rs2    <= p_rs2;
            out_p_rd     <= new_rd;
            out_p_old_rd <= p_old_rd;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Committed mappings hold 31 distinct live tags, so the committed free list size is fixed.
   a_arch_conserve: assert property (@(posedge clk) disable iff (!rst_n)
      $countones(arch_free) == int'(NUM_PREGS - NUM_AREGS));
   a_spec_bound: assert property (@(posedge clk) disable iff (!rst_n)
      $countones(spec_free) <= int'(NUM_PREGS - NUM_AREGS) && !spec_free[0]);

endmodule
